// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : shared constants and helpers for timer counter chains     |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
package timer_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest width able to hold 0..value-1; never less than one bit.
  function automatic int clog2_f(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/mod_counter_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_counter_gen : modulo-N up/down step counter with clear, preset    |
// |                   load, same-cycle tc and registered wrap pulses      |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
module mod_counter_gen
  import timer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULO  = 7,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("mod_counter_gen: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  if (RST_VAL < 0 || RST_VAL >= MODULO) begin : g_bad_rst_val
    $error("mod_counter_gen: RST_VAL must lie in 0..MODULO-1");
  end

  // One extra bit so MODULO == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   c_modulo  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] c_max     = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_cnt;
  logic             r_carry;
  logic             r_borrow;
  logic             r_load_err;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_ok;
  logic             w_dir_up;

  assign w_at_max  = (r_cnt == c_max);
  assign w_at_zero = (r_cnt == '0);
  assign w_load_ok = ({1'b0, load_val} < c_modulo);
  assign w_dir_up  = (up == DIR_UP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= c_rst_val;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_cnt <= c_rst_val;
      end else if (load) begin
        if (w_load_ok) begin
          r_cnt <= load_val;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (en) begin
        // Wrap on the explicit bound, never on natural WIDTH overflow.
        if (w_dir_up) begin
          if (w_at_max) begin
            r_cnt   <= '0;
            r_carry <= 1'b1;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end else begin
          if (w_at_zero) begin
            r_cnt    <= c_max;
            r_borrow <= 1'b1;
          end else begin
            r_cnt <= r_cnt - WIDTH'(1);
          end
        end
      end
    end
  end

  // Zero-latency terminal count feeds the next stage's enable.
  assign tc = rst_n & en & ~clr & ~load &
              ((w_dir_up & w_at_max) | (~w_dir_up & w_at_zero));

  assign cnt      = r_cnt;
  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;

endmodule : mod_counter_gen
`default_nettype wire

// File: doc/mod_counter_gen.md
Name: mod_counter_gen

Overview:
- Parametrised modulo-N step counter for the timer chain; generalises the fixed mod-7 stage.
- Adds up/down counting, synchronous clear, range-checked preset load, and both registered and same-cycle wrap indications.
- Stages cascade: the upstream `tc` drives the downstream `en`, building sec/min/hour/day chains.
- Registered `carry`/`borrow` pulses keep the legacy one-cycle-late wrap flag for display and interrupt logic.

Parameters:
- WIDTH, 4, bit width of the count.
- MODULO, 7, number of states; count range is 0..MODULO-1. Elaboration error unless 2 <= MODULO <= 2**WIDTH.
- RST_VAL, 0, count value after reset and after `clr`. Elaboration error if RST_VAL >= MODULO.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  in  1  step request; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- clr  in  1  synchronous clear to RST_VAL.
- load  in  1  synchronous preset request.
- load_val  in  WIDTH  preset value.
- cnt  out  WIDTH  current count (registered).
- tc  out  1  combinational terminal count (see Behaviour).
- carry  out  1  registered one-cycle pulse after an up-wrap.
- borrow  out  1  registered one-cycle pulse after a down-wrap.
- load_err  out  1  registered one-cycle pulse after a rejected load.

Behaviour:
- Reset: rst_n low at a clk edge sets cnt=RST_VAL and carry=borrow=load_err=0. tc still follows its combinational equation.
- Priority per edge: rst_n > clr > load > en. Lower-priority requests in the same cycle are dropped (no queuing).
- clr: cnt<=RST_VAL; carry, borrow, load_err <=0.
- load with load_val < MODULO: cnt<=load_val; carry, borrow, load_err <=0.
- load with load_val >= MODULO: cnt unchanged; load_err<=1; carry, borrow <=0.
- en with up=1: cnt==MODULO-1 -> cnt<=0 and carry<=1; otherwise cnt<=cnt+1 and carry<=0.
- en with up=0: cnt==0 -> cnt<=MODULO-1 and borrow<=1; otherwise cnt<=cnt-1 and borrow<=0.
- Idle (no clr, load or en): cnt holds; carry, borrow, load_err <=0. Every flag is therefore exactly a one-cycle pulse.
- tc = en & ~clr & ~load & ((up & cnt==MODULO-1) | (~up & cnt==0)).
  - Asserted in the same cycle as the wrapping step, with zero latency, for cascade enable.
  - Gated by rst_n: tc=0 while rst_n is low.
- Latency:
  - cnt updates on the edge where the request is sampled.
  - carry/borrow rise on that same edge, so they are visible one cycle after tc.
- Direction change mid-count: no penalty; the new direction takes effect on the next step.
- Arithmetic: compare and wrap on the explicit MODULO bound, never on natural WIDTH overflow. MODULO == 2**WIDTH must still wrap correctly.
- Reset mid-operation: a pending flag pulse is cleared; no wrap pulse is emitted for the aborted step.

Decomposition:
- Shared package timer_pkg:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a clog2-style helper used by instantiating chains to derive WIDTH from MODULO.
- No sub-module; a single flat module with one count register, flag registers, and the tc equation.
- Cascades are built by instantiating this block, not inside it.

Test Plan (WIDTH=4, MODULO=7, RST_VAL=0):
- Up-wrap: hold rst_n=0 for 2 cycles, then en=1, up=1 for 8 cycles -> cnt 1,2,3,4,5,6,0,1; tc=1 only while cnt=6; carry=1 exactly in the cycle cnt=0.
- Down-wrap: from cnt=0, en=1, up=0 -> cnt=6, borrow pulses 1 cycle; continue down -> 5,4,3; no further borrow.
- Load: load=1, load_val=5 -> cnt=5, load_err=0. Then load_val=9 -> cnt stays 5, load_err=1 for one cycle. Load and en together at cnt=6 -> cnt=load_val, tc=0, carry=0.
- Priority: clr, load and en all high at cnt=6 -> cnt=0, carry=0, load_err=0. Also rst_n=0 with clr=0 -> cnt=0 next edge, all flags 0.
- Reset mid-operation: rst_n=0 in the same cycle as an up-wrap step at cnt=6 -> cnt=0, carry stays 0.
- Boundary params: WIDTH=3, MODULO=8, up-count 9 steps -> cnt wraps 7->0, carry pulses once. A two-stage cascade (MODULO 7 then 4, stage-2 en = stage-1 tc), 28 steps -> stage 2 wraps once.
